// File: rtl/bus_arbiter_if.sv
// Handshake and bus signals between the two requesters (IF fetch, LS
// load/store), the bus_arbiter, and the shared external memory bus.
//   master : the arbiter's view (takes requests, drives grants/done/bus)
//   slave  : the environment's view (requesters plus bus responder)
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  logic              bus_cs;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              ready_bus;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, bus_rdata, ready_bus,
    output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
           bus_cs, bus_we, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, bus_rdata, ready_bus,
    input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
           bus_cs, bus_we, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester (IF fetch / LS load-store) arbiter and sequencer for the
// shared memory bus. Grants one requester at a time with round-robin
// tie-break, latches its address/data, runs the bus until ready_bus or a
// timeout, then returns read data with a one-cycle done pulse.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bif  : bus_arbiter_if.master (requests, grants, done/rdata, bus signals)
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its bus fields
// BUSY  | bus_cs high, waiting for ready_bus or timeout; gnt in 1st cycle
// DONE  | one-cycle done pulse (plus bus_err on timeout), requests ignored
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_LS  = 1'b1;
  // Down-counter reaches 0 in the TIMEOUT-th BUSY cycle.
  localparam logic [7:0] TC_LOAD = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, last_owner_q;
  logic              first_q;
  logic              err_q;
  logic [7:0]        cnt_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  logic any_req;
  logic win_ls;
  logic timeout_hit;

  assign any_req     = bif.if_req | bif.ls_req;
  // LS wins when alone, or on a tie when IF owned the bus last.
  assign win_ls      = bif.ls_req & (~bif.if_req | (last_owner_q == OWN_IF));
  // ready_bus in the final cycle still counts as success.
  assign timeout_hit = (state_q == BUSY) && !bif.ready_bus && (cnt_q == 8'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (bif.ready_bus || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched bus fields, ownership, timer and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 8'd0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q      <= win_ls;
            last_owner_q <= win_ls;
            bus_addr_q   <= win_ls ? bif.ls_addr : bif.if_addr;
            bus_we_q     <= win_ls & bif.ls_we;
            if (win_ls) bus_wdata_q <= bif.ls_wdata;
            cnt_q        <= TC_LOAD;
            first_q      <= 1'b1;
            err_q        <= 1'b0;
          end
        end
        BUSY: begin
          first_q <= 1'b0;
          if (bif.ready_bus) begin
            if (owner_q == OWN_LS) ls_rdata_q <= bif.bus_rdata;
            else                   if_rdata_q <= bif.bus_rdata;
          end else if (cnt_q == 8'd0) begin
            err_q <= 1'b1;
            if (owner_q == OWN_LS) ls_rdata_q <= '0;
            else                   if_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bif.bus_cs  = 1'b0;
    bif.if_gnt  = 1'b0;
    bif.ls_gnt  = 1'b0;
    bif.if_done = 1'b0;
    bif.ls_done = 1'b0;
    bif.bus_err = 1'b0;
    case (state_q)
      BUSY: begin
        bif.bus_cs = 1'b1;
        bif.if_gnt = first_q & (owner_q == OWN_IF);
        bif.ls_gnt = first_q & (owner_q == OWN_LS);
      end
      DONE: begin
        bif.if_done = (owner_q == OWN_IF);
        bif.ls_done = (owner_q == OWN_LS);
        bif.bus_err = err_q;
      end
      default: ;
    endcase
  end

  assign bif.bus_we    = bus_we_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.if_rdata  = if_rdata_q;
  assign bif.ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int TO = 15;

  typedef struct {
    bit          owner;   // 0 = IF, 1 = LS
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // BUSY cycle (1-based) in which ready_bus is driven
    int          raise;   // cycle in which the request was raised
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    last_done = -100;
  int    busy_n = 0;
  bit    mon_en = 1'b0;
  bit    m_last = 1'b0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_ls_rdata = '0;
  item_t exp_q[$];
  item_t resp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bus responder: drives ready_bus in the chosen BUSY cycle of each access.
  item_t cur;
  int    rcnt = 0;
  always @(negedge clk) begin
    if (!bif.bus_cs) begin
      rcnt = 0;
      bif.ready_bus = 1'b0;
    end else begin
      if (rcnt == 0) begin
        if (resp_q.size() > 0) cur = resp_q.pop_front();
        else cur.delay = 1000;
      end
      rcnt++;
      if (rcnt == cur.delay) begin
        bif.ready_bus = 1'b1;
        bif.bus_rdata = cur.rdata;
      end else begin
        bif.ready_bus = 1'b0;
        bif.bus_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      busy_n = 0;
    end else begin
      item_t f;
      bit    err;
      int    want;
      if (bif.bus_cs) busy_n++;
      if (bif.if_gnt || bif.ls_gnt) begin
        chk("gnt_onehot", 64'(bif.if_gnt & bif.ls_gnt), 64'(0));
        chk("gnt_first_busy", 64'(busy_n), 64'(1));
        if (exp_q.size() == 0) chk("unexpected_gnt", 64'(1), 64'(0));
        else begin
          f = exp_q[0];
          chk("gnt_owner", 64'(bif.ls_gnt), 64'(f.owner));
          want = (f.raise + 1 > last_done + 2) ? f.raise + 1 : last_done + 2;
          chk("gnt_cycle", 64'(cyc), 64'(want));
        end
      end
      if (bif.bus_cs && exp_q.size() > 0) begin
        f = exp_q[0];
        chk("bus_addr", 64'(bif.bus_addr), 64'(f.addr));
        chk("bus_we", 64'(bif.bus_we), 64'(f.we));
        if (f.we) chk("bus_wdata", 64'(bif.bus_wdata), 64'(f.wdata));
      end
      if (bif.bus_err && !(bif.if_done || bif.ls_done))
        chk("err_without_done", 64'(1), 64'(0));
      if (bif.if_done || bif.ls_done) begin
        chk("done_onehot", 64'(bif.if_done & bif.ls_done), 64'(0));
        chk("done_no_cs", 64'(bif.bus_cs), 64'(0));
        if (exp_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          f   = exp_q.pop_front();
          err = (f.delay > TO);
          chk("done_owner", 64'(bif.ls_done), 64'(f.owner));
          chk("bus_err", 64'(bif.bus_err), 64'(err));
          chk("busy_cycles", 64'(busy_n), 64'(err ? TO : f.delay));
          if (f.owner) m_ls_rdata = err ? 32'h0 : f.rdata;
          else         m_if_rdata = err ? 32'h0 : f.rdata;
        end
        last_done = cyc;
        busy_n = 0;
      end
      chk("if_rdata", 64'(bif.if_rdata), 64'(m_if_rdata));
      chk("ls_rdata", 64'(bif.ls_rdata), 64'(m_ls_rdata));
    end
  end

  function automatic item_t mk_item(input bit owner);
    item_t it;
    int    r;
    it.owner = owner;
    it.we    = owner ? 1'($urandom_range(0, 1)) : 1'b0;
    it.addr  = $urandom;
    it.wdata = $urandom;
    it.rdata = $urandom;
    r = $urandom_range(0, 9);
    if (r <= 5)      it.delay = $urandom_range(1, 4);
    else if (r == 6) it.delay = TO - 1;
    else if (r == 7) it.delay = TO;
    else if (r == 8) it.delay = TO + 1;
    else             it.delay = 1000;
    it.raise = 0;
    return it;
  endfunction

  // Called at negedge+#1; returns at negedge+#1 with the scoreboard drained.
  task automatic run_round(input bit en_if, input bit en_ls, input item_t ti, input item_t tl);
    bit first_ls;
    bit got_if, got_ls;
    int n;
    ti.raise = cyc;
    tl.raise = cyc;
    if (en_if && en_ls) begin
      first_ls = (m_last == 1'b0);
      if (first_ls) begin
        exp_q.push_back(tl); exp_q.push_back(ti);
        resp_q.push_back(tl); resp_q.push_back(ti);
      end else begin
        exp_q.push_back(ti); exp_q.push_back(tl);
        resp_q.push_back(ti); resp_q.push_back(tl);
      end
      m_last = ~first_ls;
    end else if (en_ls) begin
      exp_q.push_back(tl); resp_q.push_back(tl); m_last = 1'b1;
    end else begin
      exp_q.push_back(ti); resp_q.push_back(ti); m_last = 1'b0;
    end
    bif.if_req = en_if; bif.if_addr = ti.addr;
    bif.ls_req = en_ls; bif.ls_addr = tl.addr; bif.ls_we = tl.we; bif.ls_wdata = tl.wdata;
    got_if = !en_if;
    got_ls = !en_ls;
    n = 0;
    while (!(got_if && got_ls) && n < 200) begin
      @(negedge clk); #1;
      n++;
      if (bif.if_gnt && !got_if) begin
        got_if = 1'b1; bif.if_req = 1'b0; bif.if_addr = $urandom;
      end
      if (bif.ls_gnt && !got_ls) begin
        got_ls = 1'b1; bif.ls_req = 1'b0;
        bif.ls_addr = $urandom; bif.ls_wdata = $urandom; bif.ls_we = 1'($urandom_range(0, 1));
      end
    end
    if (!(got_if && got_ls)) begin
      chk("gnt_wait_expired", 64'(1), 64'(0));
      bif.if_req = 1'b0; bif.ls_req = 1'b0;
    end
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("done_wait_expired", 64'(exp_q.size()), 64'(0));
      exp_q.delete(); resp_q.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    #1;
  endtask

  item_t a, b;
  int    n;
  bit    seen;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.if_req = 0; bif.if_addr = 0; bif.ls_req = 0; bif.ls_we = 0;
    bif.ls_addr = 0; bif.ls_wdata = 0; bif.bus_rdata = 0; bif.ready_bus = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bus_cs", 64'(bif.bus_cs), 64'(0));
    chk("rst_bus_fields", {31'(0), bif.bus_we, bif.bus_addr}, 64'(0));
    chk("rst_bus_wdata", 64'(bif.bus_wdata), 64'(0));
    chk("rst_handshake", 64'({bif.if_gnt, bif.ls_gnt, bif.if_done, bif.ls_done, bif.bus_err}), 64'(0));
    chk("rst_rdata", {bif.if_rdata, bif.ls_rdata}, 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    #1;

    // Fetch read, ready in 2nd BUSY cycle
    a = mk_item(1'b0); a.addr = 32'h100; a.rdata = 32'hDEADBEEF; a.delay = 2;
    run_round(1'b1, 1'b0, a, a);
    // Tie after reset: LS, IF, LS, IF
    repeat (2) begin
      a = mk_item(1'b0); b = mk_item(1'b1);
      run_round(1'b1, 1'b1, a, b);
    end
    // Store with inputs changed after grant
    b = mk_item(1'b1); b.we = 1'b1; b.addr = 32'h2000; b.wdata = 32'h12345678; b.delay = 3;
    run_round(1'b0, 1'b1, b, b);
    // Timeout, then ready exactly in the TIMEOUT-th cycle
    b = mk_item(1'b1); b.delay = 1000;
    run_round(1'b0, 1'b1, b, b);
    b = mk_item(1'b1); b.delay = TO;
    run_round(1'b0, 1'b1, b, b);

    for (int i = 0; i < 60; i++) begin
      int p;
      p = $urandom_range(0, 2);
      a = mk_item(1'b0); b = mk_item(1'b1);
      run_round(p != 1, p != 0, a, b);
    end

    // Reset in the 3rd BUSY cycle of a fetch
    mon_en = 1'b0;
    m_last = 1'b1;
    bif.if_req = 1'b1; bif.if_addr = $urandom;
    n = 0;
    while (!bif.if_gnt && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("midrst_gnt_seen", 64'(bif.if_gnt), 64'(1));
    bif.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("midrst_busy3_cs", 64'(bif.bus_cs), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_dropped", 64'(bif.bus_cs), 64'(0));
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen |= bif.if_done | bif.ls_done | bif.bus_err | bif.bus_cs;
      @(negedge clk);
    end
    chk("midrst_no_pulse", 64'(seen), 64'(0));
    #1;
    m_last = 1'b0; m_if_rdata = '0; m_ls_rdata = '0; last_done = -100;
    mon_en = 1'b1;
    a = mk_item(1'b0); b = mk_item(1'b1);
    run_round(1'b1, 1'b1, a, b);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter and sequencer for the shared memory bus behind the BIU. It sits between the FCU instruction-fetch port and the decoder/BIU load-store port, and the single external bus (`bus_*`, `ready_bus`). It grants one requester at a time with a round-robin tie-break, latches that requester's address and data, and drives the bus until `ready_bus` arrives or a timeout expires. It then returns read data and a one-cycle done pulse to the winner.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15: maximum number of BUSY cycles without `ready_bus` before the access is aborted; legal range 1..255.

Ports:
- `clk` input 1: single clock; all logic updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `if_req` input 1: fetch request; held high until `if_gnt`.
- `if_addr` input ADDR_W: fetch address.
- `if_gnt` output 1: one-cycle pulse; the fetch request has been accepted.
- `if_done` output 1: one-cycle pulse; the fetch access has completed.
- `if_rdata` output DATA_W: fetch read data; valid while `if_done` is high.
- `ls_req` input 1: load/store request; held high until `ls_gnt`.
- `ls_we` input 1: 1 = store, 0 = load.
- `ls_addr` input ADDR_W: load/store address.
- `ls_wdata` input DATA_W: store data.
- `ls_gnt` output 1: one-cycle pulse; the load/store request has been accepted.
- `ls_done` output 1: one-cycle pulse; the load/store access has completed.
- `ls_rdata` output DATA_W: load read data; valid while `ls_done` is high.
- `bus_cs` output 1: bus access active.
- `bus_we` output 1: bus write enable.
- `bus_addr` output ADDR_W: bus address.
- `bus_wdata` output DATA_W: bus write data.
- `bus_rdata` input DATA_W: bus read data.
- `ready_bus` input 1: bus has completed the current access.
- `bus_err` output 1: one-cycle pulse, asserted together with the owner's done; the access timed out.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner:
    - If only one request is high, that requester wins.
    - If both are high, the requester that is not `last_owner` wins.
  - On the transition edge: latch the winner's addr into `bus_addr`. For LS, also latch `ls_we` and `ls_wdata`. For IF, force `bus_we` = 0.
  - Set `owner` and `last_owner` to the winner, clear the timeout counter, and go to BUSY.
- BUSY:
  - `bus_cs` = 1, driven with the latched bus fields.
  - `<owner>_gnt` = 1 in the first BUSY cycle only.
  - Each cycle with `ready_bus` = 1: capture `bus_rdata` into `<owner>_rdata` (for stores too) and go to DONE.
  - Otherwise increment the counter.
  - If TIMEOUT consecutive BUSY cycles pass with `ready_bus` low: go to DONE with the error flag set and `rdata` forced to 0.
  - `ready_bus` sampled high in the TIMEOUT-th BUSY cycle counts as success.
- DONE:
  - `bus_cs` = 0.
  - `<owner>_done` = 1, and `bus_err` = 1 if the access timed out.
  - Go to IDLE next cycle.
  - No request is sampled while in DONE.
- `last_owner` resets to IF, so LS wins the first tie after reset.
- Requests are sampled only in IDLE. Requests raised during BUSY or DONE wait.
- `if_rdata` and `ls_rdata` hold their last value until the next completion to the same owner.
- `ls_we`, `ls_addr`, `ls_wdata`, and `if_addr` are ignored outside the IDLE capture edge.

## Timing
- Reset values: `bus_cs`, `bus_we`, `bus_addr`, `bus_wdata`, both gnt, both done, both rdata, `bus_err`, and `owner` are all 0. `last_owner` resets to IF.
- Latency:
  - The request is sampled in IDLE at edge N.
  - `bus_cs` and `gnt` go high in cycle N+1.
  - If `ready_bus` is high in cycle N+k (k≥1), done is high in cycle N+k+1.
- Minimum occupancy is 3 cycles per access (IDLE, BUSY, DONE).
- Back-to-back requests are granted on the IDLE edge following DONE.
- With both requests held continuously, grants alternate strictly between LS and IF.
- `rst` mid-access: next edge `bus_cs` = 0 and state = IDLE. No done or err pulse is issued for the aborted access, and `last_owner` returns to IF.
- `rst` overrides every other input in the same cycle.

## Test plan
- Fetch read: after reset, `if_req`=1 with `if_addr`=0x100. Expect `bus_cs`=1, `bus_addr`=0x100, `bus_we`=0, and `if_gnt` one cycle. Apply `ready_bus` with `bus_rdata`=0xDEADBEEF in the 2nd BUSY cycle. Expect `if_done`=1 with `if_rdata`=0xDEADBEEF exactly one cycle later, and `ls_done` never asserted.
- Simultaneous requests after reset: `if_req` and `ls_req` high together. Expect the LS grant first and the IF grant on the edge after LS DONE. Holding both for four accesses gives the grant order LS, IF, LS, IF.
- Store: `ls_req`=1, `ls_we`=1, `ls_addr`=0x2000, `ls_wdata`=0x12345678, then change the inputs after `ls_gnt`. Expect the bus to keep showing `bus_we`=1, `bus_addr`=0x2000, `bus_wdata`=0x12345678 until `ready_bus`, followed by `ls_done`.
- Timeout with TIMEOUT=15 and `ready_bus` held low: expect exactly 15 BUSY cycles, then `ls_done`=1 and `bus_err`=1 in the same cycle with `ls_rdata`=0, then return to IDLE. A second run with `ready_bus` high in BUSY cycle 15 gives `bus_err`=0.
- Reset mid-access: assert `rst` in the 3rd BUSY cycle. Expect `bus_cs`=0 on the next edge, no done or err pulse, and a following tie granted to LS.
